// File: rtl/sequential_divider.sv
// Iterative radix-2 restoring divider for the MDU HI/LO path (32-bit, signed/unsigned).
// Define DIVIDER_ZERO_FAST_PATH_EN to skip iteration when the divisor is zero.
module sequential_divider (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        isSigned,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        divideByZero
);

   typedef logic [31:0] int_t;
   typedef enum logic [1:0] {IDLE, PREPARE, ITERATE, FIXUP} state_t;

   state_t      state, state_n;
   int_t        dvd_r, dvs_r;
   logic        sgn_r;
   logic        q_neg, r_neg;
   int_t        q_mag, d_mag, prem;
   logic [4:0]  cnt;
   logic [32:0] shifted, trial;
   logic        done_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      shifted = {prem, q_mag[31]};
      trial   = shifted - {1'b0, d_mag};
      unique case (state)
         IDLE:    if (start) state_n = PREPARE;
         PREPARE: begin
`ifdef DIVIDER_ZERO_FAST_PATH_EN
            state_n = (dvs_r == '0) ? FIXUP : ITERATE;
`else
            state_n = ITERATE;
`endif
         end
         ITERATE: if (cnt == 5'd31) state_n = FIXUP;
         FIXUP: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // q_mag shifts dividend bits out of the top while quotient bits enter at the bottom
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         divideByZero <= 1'b0;
         dvd_r        <= '0;
         dvs_r        <= '0;
         sgn_r        <= 1'b0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         q_mag        <= '0;
         d_mag        <= '0;
         prem         <= '0;
         cnt          <= '0;
      end else begin
         busy <= (state_n != IDLE);
         done <= done_n;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dvd_r <= dividend;
                  dvs_r <= divisor;
                  sgn_r <= isSigned;
               end
            end
            PREPARE: begin
               q_neg <= sgn_r & (dvd_r[31] ^ dvs_r[31]);
               r_neg <= sgn_r & dvd_r[31];
               q_mag <= (sgn_r && dvd_r[31]) ? -dvd_r : dvd_r;
               d_mag <= (sgn_r && dvs_r[31]) ? -dvs_r : dvs_r;
               prem  <= '0;
               cnt   <= '0;
            end
            ITERATE: begin
               if (!trial[32]) begin
                  prem  <= trial[31:0];
                  q_mag <= {q_mag[30:0], 1'b1};
               end else begin
                  prem  <= shifted[31:0];
                  q_mag <= {q_mag[30:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
            end
            FIXUP: begin
               if (dvs_r == '0) begin
                  quotient     <= '1;
                  remainder    <= dvd_r;
                  divideByZero <= 1'b1;
               end else begin
                  quotient     <= q_neg ? -q_mag : q_mag;
                  remainder    <= r_neg ? -prem : prem;
                  divideByZero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized and directed bench for sequential_divider against a 64-bit arithmetic model.
module tb_sequential_divider;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        isSigned;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        divideByZero;

   int checks = 0;
   int errors = 0;

`ifdef DIVIDER_ZERO_FAST_PATH_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 34;
`endif

   always #5 clock = ~clock;

   sequential_divider dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .isSigned     (isSigned),
      .dividend     (dividend),
      .divisor      (divisor),
      .busy         (busy),
      .done         (done),
      .quotient     (quotient),
      .remainder    (remainder),
      .divideByZero (divideByZero)
   );

   function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      longint x, y, t;
      z = (b == 0);
      if (b == 0) begin
         q = '1;
         r = a;
         return;
      end
      if (s) begin
         x = $signed(a);
         y = $signed(b);
      end else begin
         x = {32'b0, a};
         y = {32'b0, b};
      end
      t = x / y;
      q = t[31:0];
      t = x % y;
      r = t[31:0];
   endfunction

   // caller is at a negedge; start is sampled at the following posedge
   task automatic do_start(input bit s, input logic [31:0] a, input logic [31:0] b);
      isSigned = s;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      isSigned = 1'($urandom);
   endtask

   task automatic wait_done(input int poke_at, output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clock);
         lat++;
         if (lat == poke_at) begin
            start    = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            isSigned = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      isSigned = 1'b0;
      dividend = '0;
      divisor = '0;
      #1;
      checks++;
      if ({busy, done, divideByZero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                  busy, done, divideByZero, quotient, remainder);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      bit          ds [7] = '{0, 1, 1, 1, 0, 1, 0};
      logic [31:0] da [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                              32'h80000000, 32'h12345678, 32'h12345678};
      logic [31:0] db [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] eq, er;
      logic        ez;
      int          lat, exp_lat;
      bit          bok;
      for (int i = 0; i < 7; i++) begin
         model(ds[i], da[i], db[i], eq, er, ez);
         exp_lat = (db[i] == 0) ? ZLAT : 34;
         @(negedge clock);
         do_start(ds[i], da[i], db[i]);
         wait_done(-1, lat, bok);
         checks++;
         if (lat != exp_lat || !bok || busy !== 1'b0) begin
            errors++;
            $display("FAIL dir%0d_timing got lat=%0d busy_ok=%b busy_at_done=%b want lat=%0d 1 0",
                     i, lat, bok, busy, exp_lat);
         end
         checks++;
         if (quotient !== eq || remainder !== er || divideByZero !== ez) begin
            errors++;
            $display("FAIL dir%0d_result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, quotient, remainder, divideByZero, eq, er, ez);
         end
         @(negedge clock);
         checks++;
         if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL dir%0d_pulse got done=%b q=%h r=%h want done=0 q=%h r=%h",
                     i, done, quotient, remainder, eq, er);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, eq, er;
      logic        ez;
      bit          s, bok;
      int          lat, exp_lat;
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFFFFFF;
            2:       b = $urandom_range(1, 20);
            3:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         model(s, a, b, eq, er, ez);
         exp_lat = (b == 0) ? ZLAT : 34;
         @(negedge clock);
         do_start(s, a, b);
         wait_done(-1, lat, bok);
         checks++;
         if (lat != exp_lat || !bok) begin
            errors++;
            $display("FAIL rnd%0d_timing got lat=%0d busy_ok=%b want lat=%0d busy_ok=1",
                     i, lat, bok, exp_lat);
         end
         checks++;
         if (quotient !== eq || remainder !== er || divideByZero !== ez) begin
            errors++;
            $display("FAIL rnd%0d_result s=%b %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, s, a, b, quotient, remainder, divideByZero, eq, er, ez);
         end
      end
   endtask

   task automatic test_ignore_busy_start();
      logic [31:0] eq, er;
      logic        ez;
      int          lat;
      bit          bok;
      model(1'b1, 32'hFFFF0000, 32'd12345, eq, er, ez);
      @(negedge clock);
      do_start(1'b1, 32'hFFFF0000, 32'd12345);
      wait_done(5, lat, bok);
      checks++;
      if (lat != 34 || quotient !== eq || remainder !== er || divideByZero !== ez) begin
         errors++;
         $display("FAIL ignore_start got lat=%0d q=%h r=%h z=%b want lat=34 q=%h r=%h z=%b",
                  lat, quotient, remainder, divideByZero, eq, er, ez);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_idle got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] eq, er;
      logic        ez;
      int          lat;
      bit          bok;
      @(negedge clock);
      do_start(1'b0, 32'd1000, 32'd3);
      wait_done(-1, lat, bok);
      checks++;
      if (lat != 34 || quotient !== 32'd333 || remainder !== 32'd1) begin
         errors++;
         $display("FAIL b2b_first got lat=%0d q=%h r=%h want lat=34 q=%h r=%h",
                  lat, quotient, remainder, 32'd333, 32'd1);
      end
      model(1'b1, 32'hFFFFFC18, 32'd7, eq, er, ez);
      do_start(1'b1, 32'hFFFFFC18, 32'd7);
      wait_done(-1, lat, bok);
      checks++;
      if (lat != 34 || !bok || quotient !== eq || remainder !== er || divideByZero !== ez) begin
         errors++;
         $display("FAIL b2b_second got lat=%0d busy_ok=%b q=%h r=%h want lat=34 q=%h r=%h",
                  lat, bok, quotient, remainder, eq, er);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] eq, er;
      logic        ez;
      int          lat;
      bit          bok, saw_done;
      @(negedge clock);
      do_start(1'b0, 32'hDEADBEEF, 32'd3);
      repeat (11) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, divideByZero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                  busy, done, divideByZero, quotient, remainder);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_abort got activity=1 want 0");
      end
      model(1'b1, 32'h7FFFFFFF, 32'hFFFFFFF0, eq, er, ez);
      @(negedge clock);
      do_start(1'b1, 32'h7FFFFFFF, 32'hFFFFFFF0);
      wait_done(-1, lat, bok);
      checks++;
      if (lat != 34 || quotient !== eq || remainder !== er || divideByZero !== ez) begin
         errors++;
         $display("FAIL reset_recover got lat=%0d q=%h r=%h want lat=34 q=%h r=%h",
                  lat, quotient, remainder, eq, er);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_busy_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
